// File: rtl/wb_unified_mem_arbiter.sv
// Two-master (fetch iwb / data dwb) to one-slave Wishbone classic arbiter sharing the unified memory.
// Latency: grant registered one cycle after request; slave ack/err forwarded combinationally; 1-cycle IDLE gap between grants.
// Backpressure: a master waits for its grant; data wins unless STARVE_LIMIT data grants were issued while a fetch was pending.
// Ports: iwb slave port (i_*), dwb slave port (d_*), memory master port (m_*), grant_o status (00 idle, 01 fetch, 10 data).
module wb_unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  // instruction fetch master
  input  logic [ADDR_W-1:0]   i_adr_i,
  input  logic                i_cyc_i,
  input  logic                i_stb_i,
  output logic [DATA_W-1:0]   i_dat_o,
  output logic                i_ack_o,
  output logic                i_err_o,
  // data master
  input  logic [ADDR_W-1:0]   d_adr_i,
  input  logic [DATA_W-1:0]   d_dat_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic                d_cyc_i,
  input  logic                d_stb_i,
  output logic [DATA_W-1:0]   d_dat_o,
  output logic                d_ack_o,
  output logic                d_err_o,
  // memory slave
  output logic [ADDR_W-1:0]   m_adr_o,
  output logic [DATA_W-1:0]   m_dat_o,
  input  logic [DATA_W-1:0]   m_dat_i,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_sel_o,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  input  logic                m_ack_i,
  input  logic                m_err_i,
  // status
  output logic [1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 2);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  // Encoding doubles as the grant_o status code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS_I = 2'b01,
    BUS_D = 2'b10
  } state_t;

  state_t          state;
  logic [SC_W-1:0] starve_cnt;
  logic [WD_W-1:0] wd_cnt;

  logic req_i, req_d;
  logic in_bus, cyc_g, stb_g, live;
  logic wd_hit, fwd_ack, fwd_err, done;
  logic starved;

  assign req_i   = i_cyc_i & i_stb_i;
  assign req_d   = d_cyc_i & d_stb_i;
  assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign grant_o = state;

  always_comb begin
    cyc_g = 1'b0;
    stb_g = 1'b0;
    case (state)
      BUS_I:   begin cyc_g = i_cyc_i; stb_g = i_stb_i; end
      BUS_D:   begin cyc_g = d_cyc_i; stb_g = d_stb_i; end
      default: begin cyc_g = 1'b0;    stb_g = 1'b0;    end
    endcase
  end

  // A master that drops cyc mid-grant aborts silently: nothing is forwarded.
  assign in_bus  = (state != IDLE);
  assign live    = in_bus & cyc_g;
  // Watchdog fires only when the slave stays silent; a late ack still wins.
  assign wd_hit  = live & ~m_ack_i & ~m_err_i & (wd_cnt == WD_W'(TIMEOUT - 1));
  // Err dominates a simultaneous ack.
  assign fwd_ack = live & m_ack_i & ~m_err_i;
  assign fwd_err = live & (m_err_i | wd_hit);
  assign done    = in_bus & (~cyc_g | m_ack_i | m_err_i | wd_hit);

  assign i_dat_o = m_dat_i;
  assign d_dat_o = m_dat_i;
  assign i_ack_o = fwd_ack & (state == BUS_I);
  assign i_err_o = fwd_err & (state == BUS_I);
  assign d_ack_o = fwd_ack & (state == BUS_D);
  assign d_err_o = fwd_err & (state == BUS_D);

  always_comb begin
    m_adr_o = '0;
    m_dat_o = '0;
    m_we_o  = 1'b0;
    m_sel_o = '0;
    case (state)
      BUS_I: begin
        m_adr_o = i_adr_i;
        m_sel_o = {SEL_W{1'b1}};
      end
      BUS_D: begin
        m_adr_o = d_adr_i;
        m_dat_o = d_dat_i;
        m_we_o  = d_we_i;
        m_sel_o = d_sel_i;
      end
      default: ;
    endcase
    // Watchdog abort releases the slave in the same cycle the err is returned.
    m_cyc_o = cyc_g & ~wd_hit;
    m_stb_o = stb_g & ~wd_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (req_d && req_i && starved) begin
            state      <= BUS_I;
            starve_cnt <= '0;
          end else if (req_d) begin
            state <= BUS_D;
            // Count only data grants that actually hold off a waiting fetch.
            if (!req_i)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + SC_W'(1);
          end else if (req_i) begin
            state      <= BUS_I;
            starve_cnt <= '0;
          end
        end
        BUS_I, BUS_D: begin
          if (done)
            state <= IDLE;
          else
            wd_cnt <= wd_cnt + WD_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed, table-driven check of the unified-memory arbiter (STARVE_LIMIT=2 and STARVE_LIMIT=0, TIMEOUT=8).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Multi-cycle corners (watchdog, async reset mid-transfer, zero starve limit) are hand-written sequences.
module tb_wb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] i_adr, d_adr, d_dat, m_dat;
  logic        i_cyc, i_stb, d_we, d_cyc, d_stb, m_ack, m_err;
  logic [3:0]  d_sel;

  logic [31:0] i_dat_o, d_dat_o, m_adr_o, m_dat_o;
  logic        i_ack_o, i_err_o, d_ack_o, d_err_o, m_we_o, m_cyc_o, m_stb_o;
  logic [3:0]  m_sel_o;
  logic [1:0]  grant_o;

  logic [31:0] z_i_dat, z_d_dat, z_m_adr, z_m_dat;
  logic        z_i_ack, z_i_err, z_d_ack, z_d_err, z_m_we, z_m_cyc, z_m_stb;
  logic [3:0]  z_m_sel;
  logic [1:0]  z_grant;

  wb_unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_adr_i(i_adr), .i_cyc_i(i_cyc), .i_stb_i(i_stb),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_adr_i(d_adr), .d_dat_i(d_dat), .d_we_i(d_we), .d_sel_i(d_sel),
    .d_cyc_i(d_cyc), .d_stb_i(d_stb),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_ack_i(m_ack), .m_err_i(m_err), .grant_o(grant_o)
  );

  wb_unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0), .TIMEOUT(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_adr_i(i_adr), .i_cyc_i(i_cyc), .i_stb_i(i_stb),
    .i_dat_o(z_i_dat), .i_ack_o(z_i_ack), .i_err_o(z_i_err),
    .d_adr_i(d_adr), .d_dat_i(d_dat), .d_we_i(d_we), .d_sel_i(d_sel),
    .d_cyc_i(d_cyc), .d_stb_i(d_stb),
    .d_dat_o(z_d_dat), .d_ack_o(z_d_ack), .d_err_o(z_d_err),
    .m_adr_o(z_m_adr), .m_dat_o(z_m_dat), .m_dat_i(m_dat), .m_we_o(z_m_we),
    .m_sel_o(z_m_sel), .m_cyc_o(z_m_cyc), .m_stb_o(z_m_stb),
    .m_ack_i(m_ack), .m_err_i(m_err), .grant_o(z_grant)
  );

  typedef struct packed {
    logic        i_cs;
    logic [31:0] i_adr;
    logic        d_cs;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_adr;
    logic [31:0] d_dat;
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_dat;
  } in_t;

  typedef struct packed {
    logic [1:0]  grant;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic        i_ack;
    logic        i_err;
    logic        d_ack;
    logic        d_err;
    logic [31:0] i_dat;
    logic [31:0] d_dat;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic in_t mk_in(logic ic, logic [31:0] ia, logic dc, logic dwe, logic [3:0] dsel,
                                logic [31:0] da, logic [31:0] dd, logic ma, logic me, logic [31:0] md);
    in_t v;
    v.i_cs = ic; v.i_adr = ia; v.d_cs = dc; v.d_we = dwe; v.d_sel = dsel;
    v.d_adr = da; v.d_dat = dd; v.m_ack = ma; v.m_err = me; v.m_dat = md;
    return v;
  endfunction

  function automatic out_t mk_out(logic [1:0] g, logic cs, logic we, logic [3:0] sel, logic [31:0] adr,
                                  logic [31:0] wdat, logic ia, logic ie, logic da, logic de, logic [31:0] rdat);
    out_t o;
    o.grant = g; o.m_cyc = cs; o.m_stb = cs; o.m_we = we; o.m_sel = sel;
    o.m_adr = adr; o.m_dat = wdat; o.i_ack = ia; o.i_err = ie; o.d_ack = da; o.d_err = de;
    o.i_dat = rdat; o.d_dat = rdat;
    return o;
  endfunction

  function automatic out_t idle_out(logic [31:0] rdat);
    return mk_out(2'b00, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, rdat);
  endfunction

  function automatic out_t sample();
    out_t o;
    o.grant = grant_o; o.m_cyc = m_cyc_o; o.m_stb = m_stb_o; o.m_we = m_we_o; o.m_sel = m_sel_o;
    o.m_adr = m_adr_o; o.m_dat = m_dat_o; o.i_ack = i_ack_o; o.i_err = i_err_o;
    o.d_ack = d_ack_o; o.d_err = d_err_o; o.i_dat = i_dat_o; o.d_dat = d_dat_o;
    return o;
  endfunction

  task automatic apply(input in_t v);
    i_cyc = v.i_cs; i_stb = v.i_cs; i_adr = v.i_adr;
    d_cyc = v.d_cs; d_stb = v.d_cs; d_we = v.d_we; d_sel = v.d_sel;
    d_adr = v.d_adr; d_dat = v.d_dat;
    m_ack = v.m_ack; m_err = v.m_err; m_dat = v.m_dat;
  endtask

  task automatic chk_o(input string nm, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] F = 4'hF;

  initial begin
    in_t  both_s;
    out_t st_d, st_i;
    logic ics0 [8];
    logic [1:0] g0 [8];

    // main-table vectors (u_dut, STARVE_LIMIT=2); state listed is the one during the vector
    vecs.push_back('{"rel_grant",  mk_in(1'b1, 32'h200, 1'b1, 1'b0, F, 32'h300, 32'h0, 1'b1, 1'b0, 32'hAA),
                     mk_out(2'b10, 1'b1, 1'b0, F, 32'h300, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAA)});
    vecs.push_back('{"gap",        mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});
    vecs.push_back('{"fetch_req",  mk_in(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});
    vecs.push_back('{"fetch_wait", mk_in(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0),
                     mk_out(2'b01, 1'b1, 1'b0, F, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)});
    vecs.push_back('{"fetch_ack",  mk_in(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h13),
                     mk_out(2'b01, 1'b1, 1'b0, F, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13)});
    vecs.push_back('{"fetch_idle", mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h13), idle_out(32'h13)});
    vecs.push_back('{"wr_req",     mk_in(1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h1000, 32'h1, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});
    vecs.push_back('{"wr_bus",     mk_in(1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h1000, 32'h1, 1'b0, 1'b0, 32'h0),
                     mk_out(2'b10, 1'b1, 1'b1, 4'h1, 32'h1000, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)});
    vecs.push_back('{"wr_ack",     mk_in(1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h1000, 32'h1, 1'b1, 1'b0, 32'h0),
                     mk_out(2'b10, 1'b1, 1'b1, 4'h1, 32'h1000, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0)});
    vecs.push_back('{"wr_idle",    mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});
    vecs.push_back('{"ierr_req",   mk_in(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});
    vecs.push_back('{"ierr_both",  mk_in(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD),
                     mk_out(2'b01, 1'b1, 1'b0, F, 32'h104, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD)});
    vecs.push_back('{"ierr_idle",  mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});
    vecs.push_back('{"abort_req",  mk_in(1'b0, 32'h0, 1'b1, 1'b0, F, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});
    vecs.push_back('{"abort_bus",  mk_in(1'b0, 32'h0, 1'b1, 1'b0, F, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0),
                     mk_out(2'b10, 1'b1, 1'b0, F, 32'h2000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)});
    vecs.push_back('{"abort_drop", mk_in(1'b0, 32'h0, 1'b0, 1'b0, F, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0),
                     mk_out(2'b10, 1'b0, 1'b0, F, 32'h2000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)});
    vecs.push_back('{"abort_idle", mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), idle_out(32'h0)});

    // starvation: both masters always requesting, slave acks immediately -> D,D,I,D,D,I
    both_s = mk_in(1'b1, 32'h10, 1'b1, 1'b0, F, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
    st_d   = mk_out(2'b10, 1'b1, 1'b0, F, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    st_i   = mk_out(2'b01, 1'b1, 1'b0, F, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      vecs.push_back('{$sformatf("starve_idle%0d", k), both_s, idle_out(32'h0)});
      vecs.push_back('{$sformatf("starve_gnt%0d", k), both_s, (k == 2 || k == 5) ? st_i : st_d});
    end

    // ---- reset with both masters requesting
    rst_n = 1'b0;
    apply(mk_in(1'b1, 32'h200, 1'b1, 1'b0, F, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_o("reset_outputs", sample(), idle_out(32'h0));
    rst_n = 1'b1;
    #1;
    chk_o("first_cycle_after_release", sample(), idle_out(32'h0));
    step();

    // ---- table
    foreach (vecs[n]) begin
      apply(vecs[n].stim);
      @(negedge clk);
      chk_o(vecs[n].name, sample(), vecs[n].exp);
      step();
    end

    // ---- watchdog: slave never answers, fetch pending behind the data grant
    apply(mk_in(1'b1, 32'h40, 1'b1, 1'b0, F, 32'h3000, 32'h0, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    chk("wd_idle_grant", 32'(grant_o), 32'h0);
    step();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("wd_grant_c%0d", k), 32'(grant_o), 32'h2);
      chk($sformatf("wd_cyc_c%0d", k), 32'(m_cyc_o), (k == 8) ? 32'h0 : 32'h1);
      chk($sformatf("wd_derr_c%0d", k), 32'(d_err_o), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("wd_dack_c%0d", k), 32'(d_ack_o), 32'h0);
      step();
    end
    d_cyc = 1'b0; d_stb = 1'b0;
    @(negedge clk);
    chk("wd_back_idle", 32'(grant_o), 32'h0);
    step();
    @(negedge clk);
    chk("wd_fetch_grant", 32'(grant_o), 32'h1);
    chk("wd_fetch_adr", m_adr_o, 32'h40);
    m_ack = 1'b1; m_dat = 32'h55;
    #1;
    chk("wd_fetch_ack", 32'(i_ack_o), 32'h1);
    chk("wd_fetch_dat", i_dat_o, 32'h55);
    step();
    apply(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    step();

    // ---- asynchronous reset in the middle of a data transfer
    apply(mk_in(1'b0, 32'h0, 1'b1, 1'b0, F, 32'h5000, 32'h0, 1'b0, 1'b0, 32'h0));
    step();
    chk("mid_pre_cyc", 32'(m_cyc_o), 32'h1);
    m_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(m_cyc_o), 32'h0);
    chk("mid_rst_grant", 32'(grant_o), 32'h0);
    chk("mid_rst_acks", {28'h0, i_ack_o, i_err_o, d_ack_o, d_err_o}, 32'h0);

    // ---- STARVE_LIMIT=0 instance: a pending fetch always wins; data only when fetch is idle
    ics0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    g0   = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    apply(mk_in(1'b1, 32'h10, 1'b1, 1'b0, F, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      i_cyc = ics0[c]; i_stb = ics0[c];
      @(negedge clk);
      chk($sformatf("lim0_grant_c%0d", c), 32'(z_grant), 32'(g0[c]));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
